// File: rtl/am2302_pkg.sv
// Shared types, status codes and checksum helper for the AM2302 single-wire reader.
package am2302_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitResp,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StDone
  } state_e;

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrNoResp   = 2'd1;
  localparam logic [1:0] ErrTimeout  = 2'd2;
  localparam logic [1:0] ErrChecksum = 2'd3;

  // Widest frame the checksum helper accepts; frames are zero-extended to this.
  localparam int unsigned MaxFrameBits = 248;

  // True when the low byte equals the mod-256 sum of the other n_bytes-1 bytes.
  function automatic logic checksum_match(input logic [MaxFrameBits-1:0] f,
                                          input int unsigned n_bytes);
    logic [15:0] sum;
    sum = '0;
    for (int unsigned i = 1; i < MaxFrameBits / 8; i++) begin
      if (i < n_bytes) begin
        sum = sum + {8'h00, f[i*8 +: 8]};
      end
    end
    return sum[7:0] == f[7:0];
  endfunction

endpackage

// File: rtl/am2302_sync.sv
// Two-flop synchroniser for the open-drain data line; resets to the idle (high) level.
module am2302_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/am2302_reader.sv
// AM2302 single-wire reader: issues the host start pulse, times the sensor response and
// data bits on the synchronised line, and publishes the frame with a status code.
module am2302_reader
  import am2302_pkg::*;
#(
  parameter int unsigned CLK_PER_US    = 50,
  parameter int unsigned START_LOW_US  = 1000,
  parameter int unsigned BIT_THRESH_US = 48,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned DATA_BITS     = 40
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  inout  wire                  SDA,
  output logic                 busy,
  output logic [DATA_BITS-1:0] frame,
  output logic                 data_valid,
  output logic                 checksum_ok,
  output logic [1:0]           error
);

  localparam int unsigned StartCyc   = START_LOW_US * CLK_PER_US;
  localparam int unsigned TimeoutCyc = TIMEOUT_US * CLK_PER_US;
  localparam int unsigned ThreshCyc  = BIT_THRESH_US * CLK_PER_US;
  localparam int unsigned MaxA       = (StartCyc > TimeoutCyc) ? StartCyc : TimeoutCyc;
  localparam int unsigned MaxCyc     = (MaxA > ThreshCyc) ? MaxA : ThreshCyc;
  localparam int unsigned CntW       = $clog2(MaxCyc) + 1;
  localparam int unsigned BcW        = $clog2(DATA_BITS + 1);
  localparam int unsigned PadW       = MaxFrameBits - DATA_BITS;

  localparam logic [CntW-1:0] StartLast  = CntW'(StartCyc - 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TimeoutCyc);
  localparam logic [CntW-1:0] ThreshCnt  = CntW'(ThreshCyc);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [BcW-1:0]  LastBit    = BcW'(DATA_BITS - 1);
  localparam logic [BcW-1:0]  DataBitsW  = BcW'(DATA_BITS);
  localparam logic [BcW-1:0]  BitOne     = BcW'(1);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BcW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             err_pend_q, err_pend_d;
  logic                   sda_prev_q;
  logic [DATA_BITS-1:0]   frame_q, frame_d;
  logic                   ck_q, ck_d;
  logic [1:0]             err_q, err_d;
  logic                   dv_q, dv_d;

  logic                   sda_s;
  logic                   sda_fall;
  logic                   timeout;
  logic [CntW-1:0]        cnt_inc;
  logic [DATA_BITS-1:0]   aligned;
  logic                   ck_calc;
  logic                   drive_low;

  am2302_sync u_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (SDA),
    .q_o    (sda_s)
  );

  // Open-drain: only ever pull low.
  assign SDA = drive_low ? 1'b0 : 1'bz;

  // Edge, not level: the line still reads low from our own start pulse on entering WAIT_RESP.
  assign sda_fall = sda_prev_q & ~sda_s;
  assign timeout  = cnt_q >= TimeoutCnt;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      err_pend_q <= ErrNone;
      sda_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      err_pend_q <= err_pend_d;
      sda_prev_q <= sda_s;
    end
  end

  // Next-state logic; cnt restarts at 1 on sensor edges since the detecting cycle counts.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    err_pend_d = err_pend_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d    = StStart;
          bit_cnt_d  = '0;
          shift_d    = '0;
          err_pend_d = ErrNone;
        end
      end
      StStart: begin
        if (cnt_q >= StartLast) begin
          state_d = StWaitResp;
          cnt_d   = '0;
        end
      end
      StWaitResp: begin
        if (sda_fall) begin
          state_d = StRespLow;
          cnt_d   = CntOne;
        end else if (timeout) begin
          state_d    = StDone;
          err_pend_d = ErrNoResp;
        end
      end
      StRespLow: begin
        if (sda_s) begin
          state_d = StRespHigh;
          cnt_d   = CntOne;
        end else if (timeout) begin
          state_d    = StDone;
          err_pend_d = ErrTimeout;
        end
      end
      StRespHigh: begin
        if (!sda_s) begin
          state_d = StBitLow;
          cnt_d   = CntOne;
        end else if (timeout) begin
          state_d    = StDone;
          err_pend_d = ErrTimeout;
        end
      end
      StBitLow: begin
        if (sda_s) begin
          state_d = StBitHigh;
          cnt_d   = CntOne;
        end else if (timeout) begin
          state_d    = StDone;
          err_pend_d = ErrTimeout;
        end
      end
      StBitHigh: begin
        if (!sda_s) begin
          shift_d   = {shift_q[DATA_BITS-2:0], (cnt_q >= ThreshCnt)};
          bit_cnt_d = bit_cnt_q + BitOne;
          cnt_d     = CntOne;
          state_d   = (bit_cnt_q == LastBit) ? StDone : StBitLow;
        end else if (timeout) begin
          state_d    = StDone;
          err_pend_d = ErrTimeout;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = state_q != StIdle;
    drive_low = state_q == StStart;
  end

  // Partial frames end up left-aligned with zeros below the received bits.
  assign aligned = shift_q << (DataBitsW - bit_cnt_q);
  assign ck_calc = checksum_match({{PadW{1'b0}}, aligned}, DATA_BITS / 8);

  always_comb begin
    frame_d = frame_q;
    ck_d    = ck_q;
    err_d   = err_q;
    dv_d    = 1'b0;
    if (state_q == StDone) begin
      frame_d = aligned;
      ck_d    = ck_calc;
      dv_d    = 1'b1;
      if (err_pend_q != ErrNone) begin
        err_d = err_pend_q;
      end else begin
        err_d = ck_calc ? ErrNone : ErrChecksum;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_q <= '0;
      ck_q    <= 1'b0;
      err_q   <= ErrNone;
      dv_q    <= 1'b0;
    end else begin
      frame_q <= frame_d;
      ck_q    <= ck_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
    end
  end

  assign frame       = frame_q;
  assign checksum_ok = ck_q;
  assign error       = err_q;
  assign data_valid  = dv_q;

endmodule

// File: tb/tb_am2302_reader.sv
// Directed bench: a cycle-timed sensor model drives the line for good, bad, missing,
// truncated and reset-interrupted reads.
module tb_am2302_reader;

  localparam int unsigned DataBits = 40;
  localparam int unsigned Timeout  = 200;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                sens_low = 1'b0;
  wire                 sda;
  logic                busy;
  logic [DataBits-1:0] frame;
  logic                data_valid;
  logic                checksum_ok;
  logic [1:0]          error;

  int tests = 0;
  int fails = 0;
  int dv_cnt = 0;

  pullup (sda);
  assign sda = sens_low ? 1'b0 : 1'bz;

  am2302_reader #(
    .CLK_PER_US    (1),
    .START_LOW_US  (800),
    .BIT_THRESH_US (48),
    .TIMEOUT_US    (Timeout),
    .DATA_BITS     (DataBits)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .start       (start),
    .SDA         (sda),
    .busy        (busy),
    .frame       (frame),
    .data_valid  (data_valid),
    .checksum_ok (checksum_ok),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_sda(input logic level, input int bound, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (sda === level) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_dv(input int base, input int bound, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (dv_cnt > base) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic drive_low(input int n);
    sens_low = 1'b1;
    tick(n);
    sens_low = 1'b0;
  endtask

  // Sensor side of one transaction; rst_bit >= 0 resets the DUT during that bit's high phase.
  task automatic sensor_frame(input logic [39:0] data, input int nbits, input int rst_bit);
    bit hit;
    wait_sda(1'b0, 10, hit);
    check("host_start_low", 64'(hit), 64'd1);
    check("busy_during_read", 64'(busy), 64'd1);
    wait_sda(1'b1, 1000, hit);
    check("host_release", 64'(hit), 64'd1);
    pulse_start();  // must be ignored while busy
    tick(29);
    drive_low(80);
    tick(80);
    for (int i = 0; i < nbits; i++) begin
      drive_low(50);
      if (i == rst_bit) begin
        tick(20);
        rst_n = 1'b0;
        #1;
        check("rst_sda_released", 64'(sda), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_valid", 64'(data_valid), 64'd0);
        tick(3);
        rst_n = 1'b1;
        return;
      end
      tick(data[39-i] ? 70 : 26);
    end
    drive_low(50);
  endtask

  initial begin
    bit hit;
    int dv0;
    int cycles;

    tick(3);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_data_valid", 64'(data_valid), 64'd0);
    check("reset_frame", 64'(frame), 64'd0);
    check("reset_checksum_ok", 64'(checksum_ok), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    check("reset_sda", 64'(sda), 64'd1);
    rst_n = 1'b1;
    tick(2);

    // Good frame
    dv0 = dv_cnt;
    pulse_start();
    sensor_frame(40'h12_3456_7814, 40, -1);
    wait_dv(dv0, 500, hit);
    check("r1_dv_seen", 64'(hit), 64'd1);
    check("r1_frame", 64'(frame), 64'h12_3456_7814);
    check("r1_checksum_ok", 64'(checksum_ok), 64'd1);
    check("r1_error", 64'(error), 64'd0);
    tick(20);
    check("r1_dv_once", 64'(dv_cnt), 64'(dv0 + 1));
    check("r1_busy_low", 64'(busy), 64'd0);

    // Second good frame
    dv0 = dv_cnt;
    pulse_start();
    sensor_frame(40'h9A_BCDE_F024, 40, -1);
    wait_dv(dv0, 500, hit);
    check("r2_dv_seen", 64'(hit), 64'd1);
    check("r2_frame", 64'(frame), 64'h9A_BCDE_F024);
    check("r2_checksum_ok", 64'(checksum_ok), 64'd1);
    check("r2_error", 64'(error), 64'd0);
    tick(20);
    check("r2_dv_once", 64'(dv_cnt), 64'(dv0 + 1));

    // Checksum failure
    dv0 = dv_cnt;
    pulse_start();
    sensor_frame(40'h12_3456_7815, 40, -1);
    wait_dv(dv0, 500, hit);
    check("r3_dv_seen", 64'(hit), 64'd1);
    check("r3_frame", 64'(frame), 64'h12_3456_7815);
    check("r3_checksum_ok", 64'(checksum_ok), 64'd0);
    check("r3_error", 64'(error), 64'd3);
    tick(20);
    check("r3_hold_error", 64'(error), 64'd3);

    // No sensor: only the pull-up answers
    dv0 = dv_cnt;
    pulse_start();
    wait_sda(1'b0, 10, hit);
    check("r4_host_start_low", 64'(hit), 64'd1);
    wait_sda(1'b1, 1000, hit);
    check("r4_host_release", 64'(hit), 64'd1);
    cycles = 0;
    while (dv_cnt == dv0 && cycles < 1000) begin
      tick(1);
      cycles++;
    end
    check("r4_timeout_window", 64'(cycles >= Timeout && cycles <= Timeout + 8), 64'd1);
    check("r4_error", 64'(error), 64'd1);
    check("r4_frame", 64'(frame), 64'd0);
    tick(2);
    check("r4_busy_low", 64'(busy), 64'd0);

    // Sensor stops after 20 bits
    dv0 = dv_cnt;
    pulse_start();
    sensor_frame(40'h12_3456_7814, 20, -1);
    wait_dv(dv0, 1000, hit);
    check("r5_dv_seen", 64'(hit), 64'd1);
    check("r5_error", 64'(error), 64'd2);
    check("r5_frame", 64'(frame), 64'h12_3450_0000);
    tick(5);
    check("r5_busy_low", 64'(busy), 64'd0);

    // Reset during bit 10
    dv0 = dv_cnt;
    pulse_start();
    sensor_frame(40'h12_3456_7814, 40, 10);
    tick(300);
    check("r6_no_dv", 64'(dv_cnt), 64'(dv0));
    check("r6_frame_cleared", 64'(frame), 64'd0);
    check("r6_error_cleared", 64'(error), 64'd0);
    check("r6_idle", 64'(busy), 64'd0);

    // Clean read after the interrupted one
    dv0 = dv_cnt;
    pulse_start();
    sensor_frame(40'h12_3456_7814, 40, -1);
    wait_dv(dv0, 500, hit);
    check("r7_dv_seen", 64'(hit), 64'd1);
    check("r7_frame", 64'(frame), 64'h12_3456_7814);
    check("r7_checksum_ok", 64'(checksum_ok), 64'd1);
    check("r7_error", 64'(error), 64'd0);
    tick(20);
    check("r7_dv_once", 64'(dv_cnt), 64'(dv0 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
